// File: rtl/cache_pkg.sv
// Shared types, default geometry and line-address packing for the n-way write-back cache.
package cache_pkg;

  localparam int unsigned DEF_S_OFFSET = 5;
  localparam int unsigned DEF_S_INDEX  = 3;
  localparam int unsigned DEF_NUM_WAYS = 4;

  typedef enum logic [1:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    FILL
  } state_e;

  // CPU request captured in IDLE and held until the response
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        write;
  } cpu_req_t;

  // Builds a line-aligned byte address from tag and set index
  function automatic logic [31:0] line_address(input logic [31:0] tag,
                                               input logic [31:0] index,
                                               input int unsigned s_offset,
                                               input int unsigned s_index);
    return (tag << (s_offset + s_index)) | (index << s_offset);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: next-state bits on an access and the current victim way.
// Node n has children 2n+1 (left) and 2n+2 (right); a bit of 1 steers the victim right.
module plru_tree #(
  parameter int unsigned  NUM_WAYS = 4,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [WAY_W-1:0]    access_way,
  output logic [NUM_WAYS-2:0] bits_next,
  output logic [WAY_W-1:0]    victim_way
);

  logic [WAY_W-1:0] upd_node;
  logic [WAY_W-1:0] vic_node;

  // Point every node on the accessed path away from the accessed way
  always_comb begin
    bits_next = bits;
    upd_node  = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      bits_next[upd_node] = ~access_way[WAY_W-1-l];
      upd_node = WAY_W'(2 * int'(upd_node) + 1 + int'(access_way[WAY_W-1-l]));
    end
  end

  // Walk from the root following the stored directions
  always_comb begin
    victim_way = '0;
    vic_node   = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      victim_way[WAY_W-1-l] = bits[vic_node];
      vic_node = WAY_W'(2 * int'(vic_node) + 1 + int'(bits[vic_node]));
    end
  end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back, write-allocate cache with tree PLRU replacement.
// Optional hit/miss performance counters are built when CACHE_PERF_CNT_EN is defined.
module nway_cache
  import cache_pkg::*;
#(
  parameter int unsigned  S_OFFSET = DEF_S_OFFSET,
  parameter int unsigned  S_INDEX  = DEF_S_INDEX,
  parameter int unsigned  NUM_WAYS = DEF_NUM_WAYS,
  localparam int unsigned S_LINE   = 8 * (2 ** S_OFFSET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int unsigned S_TAG  = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned SETS   = 2 ** S_INDEX;
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned WORD_W = S_OFFSET - 2;
  localparam int unsigned WORDS  = 2 ** WORD_W;
  localparam int unsigned PLRU_W = NUM_WAYS - 1;

  state_e            state_q, state_d;
  cpu_req_t          req_q;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              from_fill_q, from_fill_d;
  logic              pmem_read_d, pmem_write_d;
  logic [31:0]       pmem_address_d;
  logic [S_LINE-1:0] pmem_wdata_d;

  logic              valid_q [NUM_WAYS][SETS];
  logic              dirty_q [NUM_WAYS][SETS];
  logic [S_TAG-1:0]  tag_q   [NUM_WAYS][SETS];
  logic [S_LINE-1:0] data_q  [NUM_WAYS][SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  logic [S_TAG-1:0]  req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [WORD_W-1:0] req_word;
  logic              hit_c, any_invalid_c;
  logic [WAY_W-1:0]  hit_way_c, inv_way_c, plru_victim_c, victim_c;
  logic [PLRU_W-1:0] plru_next_c;
  logic [S_LINE-1:0] hit_line_c, merged_line_c;
  logic [31:0]       hit_word_c;
  logic              unused_bits;

  assign req_tag     = req_q.addr[31 -: S_TAG];
  assign req_idx     = req_q.addr[S_OFFSET +: S_INDEX];
  assign req_word    = req_q.addr[2 +: WORD_W];
  assign unused_bits = ^req_q.addr[1:0];

  // Tag compare across ways; the descending scan leaves the lowest invalid way
  always_comb begin
    hit_c         = 1'b0;
    hit_way_c     = '0;
    any_invalid_c = 1'b0;
    inv_way_c     = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!valid_q[w][req_idx]) begin
        any_invalid_c = 1'b1;
        inv_way_c     = WAY_W'(w);
      end
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits       (plru_q[req_idx]),
    .access_way (hit_way_c),
    .bits_next  (plru_next_c),
    .victim_way (plru_victim_c)
  );

  assign victim_c = any_invalid_c ? inv_way_c : plru_victim_c;

  // Selected word for reads and byte-merged line for writes
  always_comb begin
    hit_line_c    = data_q[hit_way_c][req_idx];
    merged_line_c = hit_line_c;
    hit_word_c    = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (WORD_W'(i) == req_word) begin
        hit_word_c = hit_line_c[i*32 +: 32];
        for (int b = 0; b < 4; b++) begin
          if (req_q.be[b]) merged_line_c[i*32 + b*8 +: 8] = req_q.wdata[b*8 +: 8];
        end
      end
    end
  end

  assign mem_resp  = (state_q == TAG_CHECK) && hit_c;
  assign mem_rdata = mem_resp ? hit_word_c : '0;

  // Next state and next memory-side request
  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    from_fill_d    = from_fill_q;
    pmem_read_d    = pmem_read;
    pmem_write_d   = pmem_write;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (hit_c) begin
          state_d     = IDLE;
          from_fill_d = 1'b0;
        end else begin
          victim_d = victim_c;
          if (dirty_q[victim_c][req_idx]) begin
            state_d        = WRITEBACK;
            pmem_write_d   = 1'b1;
            pmem_address_d = line_address(32'(tag_q[victim_c][req_idx]), 32'(req_idx),
                                          S_OFFSET, S_INDEX);
            pmem_wdata_d   = data_q[victim_c][req_idx];
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = line_address(32'(req_tag), 32'(req_idx), S_OFFSET, S_INDEX);
          end
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          state_d        = FILL;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_address_d = line_address(32'(req_tag), 32'(req_idx), S_OFFSET, S_INDEX);
        end
      end
      FILL: begin
        if (pmem_resp) begin
          state_d        = TAG_CHECK;
          pmem_read_d    = 1'b0;
          pmem_address_d = '0;
          from_fill_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      from_fill_q  <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      from_fill_q  <= from_fill_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if ((state_q == IDLE) && (mem_read || mem_write)) begin
      req_q <= cpu_req_t'{addr: mem_address, wdata: mem_wdata, be: mem_byte_enable,
                          write: mem_write};
    end
  end

  // Valid, dirty and PLRU status
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      if (mem_resp) begin
        plru_q[req_idx] <= plru_next_c;
        if (req_q.write) dirty_q[hit_way_c][req_idx] <= 1'b1;
      end
      if ((state_q == WRITEBACK) && pmem_resp) dirty_q[victim_q][req_idx] <= 1'b0;
      if ((state_q == FILL) && pmem_resp) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
    end
  end

  // Tag and line storage carry no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_q == FILL) && pmem_resp) begin
        data_q[victim_q][req_idx] <= pmem_rdata;
        tag_q[victim_q][req_idx]  <= req_tag;
      end else if (mem_resp && req_q.write) begin
        data_q[hit_way_c][req_idx] <= merged_line_c;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Hits that merely complete a fill are already accounted as misses
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == TAG_CHECK) begin
      if (hit_c && !from_fill_q && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (!hit_c && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = from_fill_q;
  assign hit_count   = '0;
  assign miss_count  = '0;
`endif

endmodule

// File: tb/tb_nway_cache.sv
// Directed and randomized checks of nway_cache against a flat byte-addressed memory model.
module tb_nway_cache;

  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       mem_address, mem_wdata, mem_rdata;
  logic              mem_read, mem_write, mem_resp;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       pmem_address;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic [31:0]       hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  nway_cache dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Backing memory (written lines only) and the CPU-visible reference image
  logic [LINE_W-1:0] pmem_store [logic [31:0]];
  logic [31:0]       ref_mem    [logic [31:0]];

  int          fills = 0, wbs = 0, both_hi = 0, rdata_leak = 0;
  logic [31:0] last_fill_addr = '0, last_wb_addr = '0;
  int          dly_max = 3;
  bit          hold_resp = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [LINE_W-1:0] fetch_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (pmem_store.exists(la)) return pmem_store[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    if (ref_mem.exists({a[31:2], 2'b00})) return ref_mem[{a[31:2], 2'b00}];
    l = fetch_line({a[31:5], 5'b0});
    l = l >> (32 * int'(a[4:2]));
    return l[31:0];
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    ref_mem[{a[31:2], 2'b00}] = w;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: random latency, optional withholding
  initial begin
    bit active = 1'b0;
    int left = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst || hold_resp || !(pmem_read || pmem_write)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          left   = int'($urandom_range(dly_max, 1));
        end
        left--;
        if (left == 0) begin
          active    = 1'b0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pmem_store[pmem_address] = pmem_wdata;
            wbs++;
            last_wb_addr = pmem_address;
          end else begin
            pmem_rdata = fetch_line(pmem_address);
            fills++;
            last_fill_addr = pmem_address;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) both_hi++;
      if (!mem_resp && (mem_rdata != '0)) rdata_leak++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // One CPU transaction; inputs are scrambled once the request has been latched
  task automatic cpu_op(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output int lat);
    int cyc;
    @(negedge clk);
    mem_address = addr; mem_read = rd_en; mem_write = wr_en;
    mem_wdata = wd; mem_byte_enable = be;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_address = $urandom; mem_wdata = $urandom; mem_byte_enable = 4'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 300);
    if (!mem_resp) check("resp_timeout", {31'b0, mem_resp}, 32'd1);
    rd  = mem_rdata;
    lat = cyc + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_mem.delete();
  endtask

  initial begin
    logic [31:0] rd, addr, wd, orig, exp_hits, exp_miss;
    logic [3:0]  be;
    int lat, f0, w0, r, nops;

    rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
    check("rst_pmem_address", pmem_address, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;

    // Cold read miss
    f0 = fills; w0 = wbs;
    cpu_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, rd, lat);
    check("cold_rdata", rd, init_word(32'h0000_0040));
    check("cold_fills", 32'(fills - f0), 32'd1);
    check("cold_wbs", 32'(wbs - w0), 32'd0);
    check("cold_fill_addr", last_fill_addr, 32'h0000_0040);
`ifdef CACHE_PERF_CNT_EN
    check("cold_miss_count", miss_count, 32'd1);
    check("cold_hit_count", hit_count, 32'd0);
`else
    check("cold_miss_count", miss_count, 32'd0);
`endif

    // Hit in the same line
    f0 = fills; w0 = wbs;
    cpu_op(1'b1, 1'b0, 32'h0000_0044, '0, '0, rd, lat);
    check("hit_rdata", rd, init_word(32'h0000_0044));
    check("hit_lat", 32'(lat), 32'd2);
    check("hit_no_pmem", 32'(fills - f0 + wbs - w0), 32'd0);
`ifdef CACHE_PERF_CNT_EN
    check("hit_count_1", hit_count, 32'd1);
`else
    check("hit_count_1", hit_count, 32'd0);
`endif

    // Partial write then read back
    orig = init_word(32'h0000_0040);
    cpu_op(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011, rd, lat);
    ref_write(32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
    cpu_op(1'b1, 1'b0, 32'h0000_0040, '0, '0, rd, lat);
    check("partial_write", rd, {orig[31:16], 16'hBEEF});

    // PLRU victim selection in set 2 with a dirty victim
    do_reset();
    f0 = fills; w0 = wbs;
    for (int t = 1; t <= 4; t++) begin
      addr = (32'(t) << 8) | 32'h40;
      wd = $urandom;
      cpu_op(1'b0, 1'b1, addr, wd, 4'hF, rd, lat);
      ref_write(addr, wd, 4'hF);
    end
    check("plru_fill4_fills", 32'(fills - f0), 32'd4);
    check("plru_fill4_wbs", 32'(wbs - w0), 32'd0);
    f0 = fills; w0 = wbs;
    cpu_op(1'b1, 1'b0, 32'h0000_0140, '0, '0, rd, lat);
    check("plru_touch_rdata", rd, ref_read(32'h0000_0140));
    check("plru_touch_no_pmem", 32'(fills - f0 + wbs - w0), 32'd0);
    f0 = fills; w0 = wbs;
    cpu_op(1'b1, 1'b0, 32'h0000_0540, '0, '0, rd, lat);
    check("plru_victim_wbs", 32'(wbs - w0), 32'd1);
    check("plru_victim_wb_addr", last_wb_addr, 32'h0000_0340);
    check("plru_victim_fill_addr", last_fill_addr, 32'h0000_0540);
    check("plru_victim_rdata", rd, ref_read(32'h0000_0540));
    cpu_op(1'b1, 1'b0, 32'h0000_0340, '0, '0, rd, lat);
    check("plru_wb_data", rd, ref_read(32'h0000_0340));

    // Reset while a fill is outstanding
    @(negedge clk);
    hold_resp = 1'b1;
    mem_address = 32'h0000_0660; mem_read = 1'b1;
    @(posedge clk);
    #1 mem_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) break;
    end
    check("fill_pending", {31'b0, pmem_read}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_fill_pread", {31'b0, pmem_read}, 32'd0);
    check("rst_fill_pwrite", {31'b0, pmem_write}, 32'd0);
    check("rst_fill_resp", {31'b0, mem_resp}, 32'd0);
    rst = 1'b0;
    hold_resp = 1'b0;
    ref_mem.delete();
    f0 = fills;
    cpu_op(1'b1, 1'b0, 32'h0000_0660, '0, '0, rd, lat);
    check("post_rst_miss", 32'(fills - f0), 32'd1);
    check("post_rst_rdata", rd, ref_read(32'h0000_0660));

    // Random traffic over four sets with long memory latency
    do_reset();
    dly_max = 20;
    f0 = fills;
    nops = 300;
    for (int n = 0; n < nops; n++) begin
      addr = (32'($urandom_range(5, 0)) << 8) | (32'($urandom_range(3, 0)) << 5)
           | (32'($urandom_range(7, 0)) << 2);
      r = int'($urandom_range(2, 0));
      if (r == 0) begin
        cpu_op(1'b1, 1'b0, addr, $urandom, 4'($urandom), rd, lat);
        check("rand_read", rd, ref_read(addr));
      end else begin
        wd = $urandom;
        be = 4'($urandom);
        cpu_op(1'b1, r == 2, addr, wd, be, rd, lat);
        if (r == 1) begin
          check("rand_rd_one", rd, ref_read(addr));
        end else begin
          ref_write(addr, wd, be);
        end
      end
    end
`ifdef CACHE_PERF_CNT_EN
    exp_miss = 32'(fills - f0);
    exp_hits = 32'(nops - (fills - f0));
`else
    exp_miss = '0;
    exp_hits = '0;
`endif
    check("rand_miss_count", miss_count, exp_miss);
    check("rand_hit_count", hit_count, exp_hits);
    check("pmem_rd_wr_overlap", 32'(both_hi), 32'd0);
    check("rdata_without_resp", 32'(rdata_leak), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
